// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out shifter. Accepts a WIDTH-bit word on a
//                valid/ready handshake and emits it LSB-first on sout, framed
//                by sout_valid / sout_last. hold freezes all state.
//                Optional macro PISO_PARITY_EN appends an even-parity bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             w_last_bit;
    logic             w_xfer;

`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    // Final data bit of the word is on sout this cycle.
    assign w_last_bit = (state_q == SHIFT) && (cnt_q == C_LAST_IDX);

    // Ready is decoded from registered state and hold only, never load_valid.
`ifdef PISO_PARITY_EN
    assign load_ready = (state_q == IDLE) || ((state_q == PARITY) && !hold);
    assign sout       = (state_q == PARITY) ? par_q : shreg_q[0];
    assign sout_last  = (state_q == PARITY);
`else
    assign load_ready = (state_q == IDLE) || (w_last_bit && !hold);
    assign sout       = shreg_q[0];
    assign sout_last  = w_last_bit;
`endif
    assign sout_valid = (state_q != IDLE);

    assign w_xfer = load_valid && load_ready;

    // Next-state logic: load on transfer, shift when not held, drain to IDLE.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                // Loads are accepted here even while hold is asserted.
                if (w_xfer) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (cnt_q != C_LAST_IDX) begin
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
                        shreg_d = '0;
`else
                        if (w_xfer) begin
                            // Back-to-back word: no idle bubble between words.
                            shreg_d = din;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                            shreg_d = '0;
                        end
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (!hold) begin
                    if (w_xfer) begin
                        state_d = SHIFT;
                        shreg_d = din;
                        cnt_d   = '0;
                        par_d   = ^din;
                    end else begin
                        state_d = IDLE;
                        shreg_d = '0;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous reset; a reset mid-word drops the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Table-driven self-checking bench for piso_serializer
//                (WIDTH=8). Honours PISO_PARITY_EN when the design is built
//                with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             load_valid = 1'b0;
    logic             hold = 1'b0;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;

    int checks = 0;
    int errors = 0;

    // One record per clock cycle: inputs driven that cycle and the outputs
    // expected during it, packed as {sout, sout_valid, sout_last, load_ready}.
    typedef struct {
        logic             lv;
        logic [WIDTH-1:0] d;
        logic             h;
        logic [3:0]       exp;
    } vec_t;

    vec_t vq[$];

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .hold       (hold),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic lv, input logic [WIDTH-1:0] d,
                                input logic h, input logic [3:0] exp);
        vec_t v;
        v.lv  = lv;
        v.d   = d;
        v.h   = h;
        v.exp = exp;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {sout, sout_valid, sout_last, load_ready};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {sout,valid,last,ready}=%b required=%b at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Apply each queued record on the falling edge, check after settling.
    task automatic run_table(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            load_valid = vq[i].lv;
            din        = vq[i].d;
            hold       = vq[i].h;
            #1;
            check($sformatf("%s_row%0d", tag, i), vq[i].exp);
        end
        @(negedge clk);
        load_valid = 1'b0;
        hold       = 1'b0;
        vq.delete();
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'b0001);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_reset", 4'b0001);

`ifdef PISO_PARITY_EN
        // 8'h07 -> 1,1,1,0,0,0,0,0 then parity 1; 8'h03 back-to-back, parity 0.
        add(1'b1, 8'h07, 1'b0, 4'b0001);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit 7: not last in parity mode
        add(1'b1, 8'h03, 1'b0, 4'b1111);   // parity bit of 07 = 1, reload
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0111);   // parity bit of 03 = 0
        add(1'b0, 8'h00, 1'b0, 4'b0001);
        run_table("parity");
`else
        // ---------------- 8'hA5 plain, with an ignored load while busy -------
        add(1'b1, 8'hA5, 1'b0, 4'b0001);   // c0 transfer
        add(1'b0, 8'h00, 1'b0, 4'b1100);   // bit0 = 1
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit1 = 0
        add(1'b0, 8'h00, 1'b0, 4'b1100);   // bit2 = 1
        add(1'b1, 8'h00, 1'b0, 4'b0100);   // bit3 = 0, load ignored
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit4 = 0
        add(1'b0, 8'h00, 1'b0, 4'b1100);   // bit5 = 1
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit6 = 0
        add(1'b0, 8'h00, 1'b0, 4'b1111);   // bit7 = 1, last, ready
        add(1'b0, 8'h00, 1'b0, 4'b0001);   // idle
        run_table("a5");

        // ---------------- 8'h01 then 8'hFF back-to-back ----------------
        add(1'b1, 8'h01, 1'b0, 4'b0001);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        for (int k = 0; k < 6; k++) add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b1, 8'hFF, 1'b0, 4'b0111);   // c8: last bit 0, new word taken
        for (int k = 0; k < 7; k++) add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1111);   // c16 last
        add(1'b0, 8'h00, 1'b0, 4'b0001);
        run_table("b2b");

        // ---------------- 8'hA5 with hold in cycles 3-4 (and during load) ----
        add(1'b1, 8'hA5, 1'b1, 4'b0001);   // load accepted while held in IDLE
        add(1'b0, 8'h00, 1'b0, 4'b1100);   // bit0 = 1
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit1 = 0
        add(1'b0, 8'h00, 1'b1, 4'b1100);   // bit2 held
        add(1'b0, 8'h00, 1'b1, 4'b1100);   // bit2 held
        add(1'b0, 8'h00, 1'b0, 4'b1100);   // bit2
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit3
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit4
        add(1'b0, 8'h00, 1'b0, 4'b1100);   // bit5
        add(1'b1, 8'h55, 1'b1, 4'b0100);   // bit6 held, load refused
        add(1'b0, 8'h00, 1'b0, 4'b0100);   // bit6
        add(1'b1, 8'h55, 1'b1, 4'b1110);   // bit7 last but held: not ready
        add(1'b0, 8'h00, 1'b0, 4'b1111);   // bit7 last, ready
        add(1'b0, 8'h00, 1'b0, 4'b0001);
        run_table("hold");

        // ---------------- asynchronous reset while shifting ----------------
        load_valid = 1'b1;
        din        = 8'hFF;
        @(negedge clk);
        load_valid = 1'b0;
        #1;
        check("pre_async_rst", 4'b1100);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_immediate", 4'b0001);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_after_rst", 4'b0001);

        // ---------------- 8'hF0 aborted after 3 bits, then 8'h3C ----------
        load_valid = 1'b1;
        din        = 8'hF0;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("f0_bit2", 4'b0100);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        add(1'b1, 8'h3C, 1'b0, 4'b0001);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b1100);
        add(1'b0, 8'h00, 1'b0, 4'b0100);
        add(1'b0, 8'h00, 1'b0, 4'b0111);
        add(1'b0, 8'h00, 1'b0, 4'b0001);
        run_table("3c");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out shifter that feeds the 2->1 mux stage one data bit per clock. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts the word out LSB-first on sout. sout_valid and sout_last frame the bit stream for the downstream consumer. A hold input freezes the stream without losing any bits.

Parameters:
WIDTH, 8, data word width in bits; legal values are 2..32.

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word; sampled only on the load handshake edge
load_valid  input  1  upstream offers din
load_ready  output  1  block can accept a word this cycle
hold  input  1  stall; when 1, all internal state is frozen
sout  output  1  current serial bit (drives mux data input)
sout_valid  output  1  sout carries a valid bit
sout_last  output  1  sout is the final bit of the current word

Behaviour:
- Interface (decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit counter=0.
- Output values during and after reset: sout=0, sout_valid=0, sout_last=0, load_ready=1.
- Internal storage: shift register shreg[WIDTH-1:0]; bit counter cnt of width $clog2(WIDTH), wraps at WIDTH-1 only by reload.
- States are IDLE and SHIFT, plus PARITY when the option is compiled in.
- Output decode:
  - sout = shreg[0]
  - sout_valid = (state != IDLE)
  - sout_last = SHIFT && cnt == WIDTH-1
  - All outputs are derived from registered state only, with no combinational path from din or load_valid.
- load_ready = IDLE || (SHIFT && cnt==WIDTH-1 && !hold). It does not depend on load_valid.
- Handshake: a transfer occurs at the rising edge where load_valid && load_ready.
  - On transfer: shreg<=din, cnt<=0, state<=SHIFT.
  - load_valid while load_ready=0 is ignored and din is not sampled.
- Latency: for a word accepted at edge N, bit 0 appears in the cycle after edge N. Bit k appears k cycles later, absent hold.
- SHIFT with hold=0 and cnt<WIDTH-1: shreg<=shreg>>1 (MSB filled with 0), cnt<=cnt+1.
- SHIFT with hold=0 and cnt==WIDTH-1:
  - If a transfer occurs, load the new word (back-to-back, no bubble).
  - Otherwise, state<=IDLE, shreg<=0.
- hold=1 in any state: state, shreg and cnt are all unchanged, so sout, sout_valid and sout_last stay stable. In IDLE with hold=1, load_ready=1 and loads are still accepted.
- Reset mid-word: the word is aborted and remaining bits are dropped. The block is IDLE the cycle after rst deasserts.
- No data is ever duplicated or skipped. Each accepted word yields exactly WIDTH valid, non-held cycles (WIDTH+1 with parity).

Optional Feature:
Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all din bits) is registered at load.
  - After bit WIDTH-1 the block enters PARITY: sout=parity bit, sout_valid=1.
  - sout_last is asserted in PARITY and not on bit WIDTH-1.
  - load_ready = IDLE || (PARITY && !hold).
  - SHIFT at cnt==WIDTH-1 with hold=0 goes to PARITY.
  - PARITY with hold=0 goes to SHIFT on a transfer, otherwise to IDLE.
  - Parity register reset value is 0.
- Undefined: no PARITY state and no parity register; behaviour is exactly as in the Behaviour section.

Test Plan:
1. Assert rst asynchronously mid-cycle while in SHIFT -> immediately sout=0, sout_valid=0, sout_last=0, load_ready=1.
2. WIDTH=8, load 8'hA5 at edge 0 -> sout=1,0,1,0,0,1,0,1 in cycles 1..8; sout_last only in cycle 8; sout_valid=0 in cycle 9.
3. Load 8'hA5, hold=1 during cycles 3-4 -> bit 2 (value 1) held for 3 cycles; same 8-bit sequence; last bit in cycle 10.
4. Load 8'h01, then present 8'hFF with load_valid=1 during cycle 8 -> 16 contiguous sout_valid cycles: 1,0x7, then 1x8; sout_last in cycles 8 and 16.
5. Load 8'hF0, pulse rst after 3 bits -> IDLE, remaining bits dropped; then load 8'h3C -> 0,0,1,1,1,1,0,0.
6. With PISO_PARITY_EN: load 8'h07 -> 9 bits, 9th bit=1, sout_last on bit 9; load 8'h03 -> 9th bit=0.
